vx_perf_ctr_ctrl: RTL and testbench

Central owner of pipeline performance counters. Accumulates per-cycle event increments from the schedule and issue stages into wrap-around counters. Arbitrates counter reads among several CSR requesters and returns one registered response at a time. Supports clear and a coherent snapshot for multi-word reads.

---
 rtl/vx_perf_pkg.sv | 30 +++
 rtl/vx_perf_rr_arb.sv | 45 ++++
 rtl/vx_perf_ctr_ctrl.sv | 129 ++++++++++++
 tb/tb_vx_perf_ctr_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_perf_pkg.sv
// Shared definitions for the pipeline performance-counter block: event map,
// counter/request types and the round-robin index helper.
package vx_perf_pkg;

    localparam int EVT_SCHED_IDLE     = 0;
    localparam int EVT_SCHED_STALL    = 1;
    localparam int EVT_IBF_STALL      = 2;
    localparam int EVT_SCB_STALL      = 3;
    localparam int EVT_SCB_FIRE       = 4;
    localparam int EVT_DISPATCH_FIRE0 = 5;
    localparam int EVT_DISPATCH_LANES = 11;
    localparam int EVT_COUNT          = EVT_DISPATCH_FIRE0 + EVT_DISPATCH_LANES;
    localparam int EVT_ADDR_BITS      = $clog2(EVT_COUNT);

    localparam int PERF_CTR_W = 44;

    typedef logic [PERF_CTR_W-1:0] perf_ctr_t;

    typedef struct packed {
        logic [EVT_ADDR_BITS-1:0] addr;
    } perf_req_t;

    // (base + off) mod n, valid for base < n and off <= n
    function automatic int perf_wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/vx_perf_rr_arb.sv
// Round-robin arbiter: one-hot grant starting from a rotating pointer; the
// pointer moves past the winner only when the grant is taken (enable high).
module vx_perf_rr_arb import vx_perf_pkg::*; #(
    parameter int NUM_REQS = 4,
    parameter int SEL_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_REQS-1:0] valid,
    input  logic                enable,
    output logic [NUM_REQS-1:0] grant,
    output logic [SEL_BITS-1:0] grant_idx
);

    logic [SEL_BITS-1:0] ptr_reg;
    logic [SEL_BITS-1:0] ptr_next;
    logic [SEL_BITS-1:0] cand_idx;
    logic                found;

    always_comb begin
        found     = 1'b0;
        cand_idx  = '0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand_idx = SEL_BITS'(perf_wrap_idx(int'(ptr_reg), k, NUM_REQS));
            if (!found && valid[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
        grant    = (enable && found) ? (NUM_REQS'(1) << grant_idx) : '0;
        ptr_next = (enable && found)
                 ? SEL_BITS'(perf_wrap_idx(int'(grant_idx), 1, NUM_REQS))
                 : ptr_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/vx_perf_ctr_ctrl.sv
// Performance counter owner: wrap-around event counters, clear, snapshot and a
// round-robin read port with one registered response. Define PERF_SNAPSHOT_EN
// to add the shadow bank so multi-word reads come from one coherent snapshot.
module vx_perf_ctr_ctrl import vx_perf_pkg::*; #(
    parameter int NUM_EVENTS    = EVT_COUNT,
    parameter int NUM_REQS      = 4,
    parameter int PERF_CTR_BITS = $bits(perf_ctr_t),
    parameter int INC_BITS      = 4,
    parameter int ADDR_BITS     = $clog2(NUM_EVENTS),
    parameter int REQ_SEL_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic [NUM_EVENTS*INC_BITS-1:0]  evt_inc,
    input  logic                            clear,
    input  logic                            snap_req,
    output logic                            snap_done,
    input  logic [NUM_REQS-1:0]             req_valid,
    input  logic [NUM_REQS*ADDR_BITS-1:0]   req_addr,
    output logic [NUM_REQS-1:0]             req_ready,
    output logic                            rsp_valid,
    output logic [REQ_SEL_BITS-1:0]         rsp_tag,
    output logic [PERF_CTR_BITS-1:0]        rsp_data,
    input  logic                            rsp_ready
);

    logic [PERF_CTR_BITS-1:0] rd_src [NUM_EVENTS];
    logic [PERF_CTR_BITS-1:0] rd_data;
    logic [ADDR_BITS-1:0]     rd_addr;
    logic [NUM_REQS-1:0]      grant;
    logic [REQ_SEL_BITS-1:0]  grant_idx;
    logic                     slot_free;
    logic                     accept;
    logic                     snap_done_reg;
    logic                     rsp_valid_reg;
    logic [REQ_SEL_BITS-1:0]  rsp_tag_reg;
    logic [PERF_CTR_BITS-1:0] rsp_data_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EVENTS; gi++) begin : g_evt
            logic [PERF_CTR_BITS-1:0] ctr_reg;

            // clear wins over the same-cycle increment
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ctr_reg <= '0;
                end else if (clear) begin
                    ctr_reg <= '0;
                end else if (enable) begin
                    ctr_reg <= ctr_reg + PERF_CTR_BITS'(evt_inc[gi*INC_BITS +: INC_BITS]);
                end
            end

`ifdef PERF_SNAPSHOT_EN
            logic [PERF_CTR_BITS-1:0] shadow_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    shadow_reg <= '0;
                end else if (snap_req) begin
                    shadow_reg <= ctr_reg;
                end
            end

            assign rd_src[gi] = shadow_reg;
`else
            assign rd_src[gi] = ctr_reg;
`endif
        end
    endgenerate

    assign slot_free = !rsp_valid_reg || rsp_ready;

    vx_perf_rr_arb #(
        .NUM_REQS (NUM_REQS),
        .SEL_BITS (REQ_SEL_BITS)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid     (req_valid),
        .enable    (slot_free),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept    = |grant;
    assign req_ready = grant;

    // Addresses past the last event fall through to zero
    always_comb begin
        rd_addr = req_addr[grant_idx*ADDR_BITS +: ADDR_BITS];
        rd_data = '0;
        for (int e = 0; e < NUM_EVENTS; e++) begin
            if (rd_addr == ADDR_BITS'(e)) begin
                rd_data = rd_src[e];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_tag_reg   <= '0;
            rsp_data_reg  <= '0;
        end else if (accept) begin
            rsp_valid_reg <= 1'b1;
            rsp_tag_reg   <= grant_idx;
            rsp_data_reg  <= rd_data;
        end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_done_reg <= 1'b0;
        end else begin
            snap_done_reg <= snap_req;
        end
    end

    assign snap_done = snap_done_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_tag   = rsp_tag_reg;
    assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_vx_perf_ctr_ctrl.sv
// Bench for vx_perf_ctr_ctrl: directed scenarios plus random traffic checked
// against an arithmetic model of counters, snapshot and round-robin reads.
module tb_vx_perf_ctr_ctrl;

    localparam int NE = 20;
    localparam int NR = 4;
    localparam int W  = 10;
    localparam int IB = 4;
    localparam int AB = 5;
    localparam int SB = 2;
    localparam int CTR_MOD = 1 << W;
`ifdef PERF_SNAPSHOT_EN
    localparam bit SNAP_EN = 1'b1;
`else
    localparam bit SNAP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [NE*IB-1:0]  evt_inc;
    logic              clear;
    logic              snap_req;
    logic              snap_done;
    logic [NR-1:0]     req_valid;
    logic [NR*AB-1:0]  req_addr;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic [SB-1:0]     rsp_tag;
    logic [W-1:0]      rsp_data;
    logic              rsp_ready;

    always #5 clk = ~clk;

    vx_perf_ctr_ctrl #(
        .NUM_EVENTS    (NE),
        .NUM_REQS      (NR),
        .PERF_CTR_BITS (W),
        .INC_BITS      (IB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .evt_inc   (evt_inc),
        .clear     (clear),
        .snap_req  (snap_req),
        .snap_done (snap_done),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_tag   (rsp_tag),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    int   n_vec = 0;
    int   n_err = 0;

    int   m_ctr    [NE];
    int   m_shadow [NE];
    logic m_rsp_valid;
    int   m_tag;
    int   m_data;
    int   m_ptr;
    logic m_snap_done;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_ctr[i]    = 0;
            m_shadow[i] = 0;
        end
        m_rsp_valid = 1'b0;
        m_tag       = 0;
        m_data      = 0;
        m_ptr       = 0;
        m_snap_done = 1'b0;
    endtask

    function automatic int model_read(input int a);
        if (a >= NE) return 0;
        return SNAP_EN ? m_shadow[a] : m_ctr[a];
    endfunction

    task automatic set_inc(input int e, input int v);
        evt_inc[e*IB +: IB] = IB'(v);
    endtask

    task automatic set_addr(input int r, input int a);
        req_addr[r*AB +: AB] = AB'(a);
    endtask

    // One clock: check ready before the edge, advance the model at the edge,
    // check registered outputs just after it.
    task automatic cycle();
        int   g;
        int   a;
        logic acc;
        logic [NR-1:0] exp_rdy;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NR; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        end
        acc     = (g >= 0) && (!m_rsp_valid || rsp_ready);
        exp_rdy = acc ? (NR'(1) << g) : '0;
        chk("req_ready", req_ready, exp_rdy);
        a = acc ? int'(req_addr[g*AB +: AB]) : 0;
        @(posedge clk);
        if (acc) begin
            m_rsp_valid = 1'b1;
            m_tag       = g;
            m_data      = model_read(a);
            m_ptr       = (g + 1) % NR;
        end else if (rsp_ready) begin
            m_rsp_valid = 1'b0;
        end
        m_snap_done = snap_req;
        if (snap_req) m_shadow = m_ctr;
        for (int i = 0; i < NE; i++) begin
            if (clear) m_ctr[i] = 0;
            else if (enable) m_ctr[i] = (m_ctr[i] + int'(evt_inc[i*IB +: IB])) % CTR_MOD;
        end
        #1;
        chk("rsp_valid", rsp_valid, m_rsp_valid);
        if (m_rsp_valid) begin
            chk("rsp_tag", rsp_tag, m_tag);
            chk("rsp_data", rsp_data, m_data);
        end
        chk("snap_done", snap_done, m_snap_done);
        if (acc) $display("read req=%0d addr=%0d -> tag=%0d data=0x%0h (model 0x%0h)",
                          g, a, rsp_tag, rsp_data, m_data);
    endtask

    task automatic snap();
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
        chk("snap_pulse", snap_done, 1);
    endtask

    task automatic do_read(input int r, input int a, input int exp, input string tag);
        req_valid    = '0;
        req_valid[r] = 1'b1;
        set_addr(r, a);
        rsp_ready    = 1'b1;
        cycle();
        req_valid = '0;
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_tag"}, rsp_tag, r);
        chk({tag, "_data"}, rsp_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        evt_inc   = '0;
        clear     = 1'b0;
        snap_req  = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_snap_done", snap_done, 0);
        chk("rst_req_ready", req_ready, 0);
        reset_n = 1'b1;

        // event 3 += 5 for four cycles
        enable = 1'b1;
        set_inc(3, 5);
        repeat (4) cycle();
        enable  = 1'b0;
        evt_inc = '0;
        snap();
        do_read(0, 3, 20, "count");

        // wrap: reach 2^W-2 then add 3
        clear = 1'b1;
        cycle();
        clear  = 1'b0;
        enable = 1'b1;
        set_inc(0, 15);
        repeat (68) cycle();
        set_inc(0, 2);
        cycle();
        set_inc(0, 3);
        cycle();
        enable  = 1'b0;
        evt_inc = '0;
        snap();
        do_read(3, 0, 1, "wrap");

        // round-robin with all requesters, then a stalled consumer
        for (int r = 0; r < NR; r++) set_addr(r, 4 + r);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_tag", rsp_tag, k % NR);
        end
        rsp_ready = 1'b0;
        repeat (3) begin
            cycle();
            chk("hold_tag", rsp_tag, 0);
            chk("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        cycle();
        chk("rr_resume_tag", rsp_tag, 1);
        req_valid = '0;
        cycle();

        // clear drops the same-cycle increment; out-of-range address reads 0
        enable = 1'b1;
        set_inc(1, 7);
        cycle();
        clear = 1'b1;
        cycle();
        clear   = 1'b0;
        enable  = 1'b0;
        evt_inc = '0;
        snap();
        do_read(1, 1, 0, "clear");
        do_read(2, 20, 0, "oor");

        // snapshot coherence
        clear = 1'b1;
        cycle();
        clear  = 1'b0;
        enable = 1'b1;
        set_inc(2, 10);
        cycle();
        enable  = 1'b0;
        evt_inc = '0;
        snap();
        enable = 1'b1;
        set_inc(2, 1);
        repeat (6) cycle();
        enable  = 1'b0;
        evt_inc = '0;
        do_read(0, 2, SNAP_EN ? 10 : 16, "snap1");
        snap();
        do_read(0, 2, 16, "snap2");

        // back-to-back snapshot requests
        snap_req = 1'b1;
        cycle();
        chk("b2b_snap0", snap_done, 1);
        cycle();
        chk("b2b_snap1", snap_done, 1);
        snap_req = 1'b0;
        cycle();
        chk("b2b_snap_end", snap_done, 0);

        // random traffic against the model
        for (int n = 0; n < 300; n++) begin
            enable    = 1'($urandom_range(0, 3) != 0);
            clear     = 1'($urandom_range(0, 15) == 0);
            snap_req  = 1'($urandom_range(0, 3) == 0);
            req_valid = NR'($urandom_range(0, (1 << NR) - 1));
            rsp_ready = 1'($urandom_range(0, 2) != 0);
            for (int e = 0; e < NE; e++) set_inc(e, $urandom_range(0, 15));
            for (int r = 0; r < NR; r++) set_addr(r, $urandom_range(0, 31));
            cycle();
        end

        // asynchronous reset with a response pending
        clear     = 1'b0;
        snap_req  = 1'b0;
        enable    = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        cycle();
        req_valid    = '0;
        req_valid[2] = 1'b1;
        set_addr(2, 3);
        rsp_ready    = 1'b0;
        cycle();
        chk("pre_rst_valid", rsp_valid, 1);
        req_valid = '0;
        enable    = 1'b0;
        reset_n   = 1'b0;
        #1;
        model_reset();
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_rsp_data", rsp_data, 0);
        chk("arst_rsp_tag", rsp_tag, 0);
        chk("arst_snap_done", snap_done, 0);
        @(posedge clk);
        #1;
        chk("arst_hold_valid", rsp_valid, 0);
        reset_n = 1'b1;
        do_read(0, 3, 0, "post_rst3");
        do_read(1, 0, 0, "post_rst0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
